// File: rtl/aes_pkg.sv
// Shared AES-128 constants, the state encoding and GF(2^8) helpers for the
// streaming encryption core.
package aes_pkg;

    localparam int AES_BLK = 128;

    typedef enum logic [1:0] {LOAD, ROUND, OUT} aesState_e;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:9][7:0] RCON = 80'h01020408102040801b36;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul2(input logic [7:0] b);
        return xtime(b);
    endfunction

    function automatic logic [7:0] mul3(input logic [7:0] b);
        return xtime(b) ^ b;
    endfunction

    // Round constant for key-expansion step rnd (1..10); zero elsewhere.
    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        if (rnd >= 4'd1 && rnd <= 4'd10)
            return RCON[rnd - 4'd1];
        return 8'h00;
    endfunction

endpackage

// File: rtl/aes_enc_stream_round.sv
// One full AES round (SubBytes, ShiftRows, optional MixColumns, AddRoundKey)
// together with the matching on-the-fly key-expansion step. Purely combinational.
module aes_round_comb
    import aes_pkg::*;
(
    input  logic [AES_BLK-1:0] state,
    input  logic [AES_BLK-1:0] roundKey,
    input  logic [7:0]         rcon,
    input  logic               lastRound,
    output logic [AES_BLK-1:0] nextState,
    output logic [AES_BLK-1:0] nextKey
);

    logic [7:0]  sb [16];
    logic [7:0]  sr [16];
    logic [7:0]  mc [16];
    logic [31:0] w  [4];
    logic [31:0] nw [4];
    logic [31:0] temp;

    // Byte i of the block is bits [127-8i -: 8]; column c holds bytes 4c..4c+3.
    always_comb begin
        nextState = '0;
        nextKey   = '0;
        for (int i = 0; i < 16; i++)
            sb[i] = sbox(state[AES_BLK-1-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sr[4*c+r] = sb[4*((c+r)%4)+r];
        for (int c = 0; c < 4; c++) begin
            mc[4*c+0] = mul2(sr[4*c]) ^ mul3(sr[4*c+1]) ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+1] = sr[4*c] ^ mul2(sr[4*c+1]) ^ mul3(sr[4*c+2]) ^ sr[4*c+3];
            mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ mul2(sr[4*c+2]) ^ mul3(sr[4*c+3]);
            mc[4*c+3] = mul3(sr[4*c]) ^ sr[4*c+1] ^ sr[4*c+2] ^ mul2(sr[4*c+3]);
        end

        for (int i = 0; i < 4; i++)
            w[i] = roundKey[AES_BLK-1-32*i -: 32];
        temp  = {sbox(w[3][23:16]) ^ rcon, sbox(w[3][15:8]), sbox(w[3][7:0]), sbox(w[3][31:24])};
        nw[0] = w[0] ^ temp;
        nw[1] = w[1] ^ nw[0];
        nw[2] = w[2] ^ nw[1];
        nw[3] = w[3] ^ nw[2];
        for (int i = 0; i < 4; i++)
            nextKey[AES_BLK-1-32*i -: 32] = nw[i];

        for (int i = 0; i < 16; i++)
            nextState[AES_BLK-1-8*i -: 8] = (lastRound ? sr[i] : mc[i]) ^ nextKey[AES_BLK-1-8*i -: 8];
    end

endmodule

// File: rtl/aes_enc_stream.sv
// Iterative AES-128 encryptor with DW-bit valid/ready beats on both sides,
// one round per clock and optional reuse of the last loaded cipher key.
module aes_enc_stream
    import aes_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic [DW-1:0] in_key,
    input  logic          in_new_key,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          busy
);

    localparam int NBEATS = AES_BLK / DW;
    localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(NBEATS - 1);

    if (DW != 8 && DW != 16 && DW != 32 && DW != 64 && DW != 128) begin : gDwCheck
        $error("aes_enc_stream: DW must be 8, 16, 32, 64 or 128");
    end

    aesState_e          fsm, fsmNext;
    logic [BW-1:0]      beatCnt;
    logic [3:0]         rnd;
    logic [AES_BLK-1:0] blk;
    logic [AES_BLK-1:0] roundKey;
    logic [AES_BLK-1:0] cipherKey;
    logic [AES_BLK-1:0] rndState;
    logic [AES_BLK-1:0] rndKey;
    logic               keyLoad;
    logic [DW-1:0]      outData;
    logic               inFire, outFire, lastBeat;

    assign in_ready  = (fsm == LOAD);
    assign out_valid = (fsm == OUT);
    assign busy      = (fsm != LOAD);
    assign out_data  = outData;
    assign inFire    = in_valid & in_ready;
    assign outFire   = out_valid & out_ready;
    assign lastBeat  = (beatCnt == LAST_BEAT);

    function automatic logic [DW-1:0] beatOf(input logic [AES_BLK-1:0] b, input logic [BW-1:0] k);
        beatOf = '0;
        for (int i = 0; i < NBEATS; i++)
            if (k == BW'(i))
                beatOf = b[AES_BLK-1-i*DW -: DW];
    endfunction

    aes_round_comb uRound (
        .state     (blk),
        .roundKey  (roundKey),
        .rcon      (rcon(rnd)),
        .lastRound (rnd == 4'd10),
        .nextState (rndState),
        .nextKey   (rndKey)
    );

    always_ff @(posedge clk) begin
        if (rst)
            fsm <= LOAD;
        else
            fsm <= fsmNext;
    end

    always_comb begin
        fsmNext = fsm;
        unique case (fsm)
            LOAD:    if (inFire && lastBeat) fsmNext = ROUND;
            ROUND:   if (rnd == 4'd10) fsmNext = OUT;
            OUT:     if (outFire && lastBeat) fsmNext = LOAD;
            default: fsmNext = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beatCnt   <= '0;
            rnd       <= '0;
            blk       <= '0;
            roundKey  <= '0;
            cipherKey <= '0;
            keyLoad   <= 1'b0;
            outData   <= '0;
        end else begin
            unique case (fsm)
                LOAD: if (inFire) begin
                    // The key-load decision is taken on beat 0 and held for the block.
                    for (int i = 0; i < NBEATS; i++) begin
                        if (beatCnt == BW'(i)) begin
                            blk[AES_BLK-1-i*DW -: DW] <= in_data;
                            if ((beatCnt == '0) ? in_new_key : keyLoad)
                                cipherKey[AES_BLK-1-i*DW -: DW] <= in_key;
                        end
                    end
                    if (beatCnt == '0)
                        keyLoad <= in_new_key;
                    beatCnt <= lastBeat ? '0 : beatCnt + 1'b1;
                    rnd     <= '0;
                end
                ROUND: begin
                    if (rnd == 4'd0) begin
                        blk      <= blk ^ cipherKey;
                        roundKey <= cipherKey;
                    end else begin
                        blk      <= rndState;
                        roundKey <= rndKey;
                    end
                    if (rnd == 4'd10)
                        outData <= rndState[AES_BLK-1 -: DW];
                    rnd <= rnd + 4'd1;
                end
                OUT: if (outFire) begin
                    if (lastBeat) begin
                        beatCnt <= '0;
                    end else begin
                        beatCnt <= beatCnt + 1'b1;
                        outData <= beatOf(blk, beatCnt + 1'b1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/aes_enc_stream.md
Name: aes_enc_stream

Overview:
Parametrised, iterative AES-128 encryption core with a streaming valid/ready interface. It replaces the fixed byte-serial load/ready front end with a configurable beat width and full back-pressure on both sides. It can also reuse the last loaded cipher key across blocks. It sits between the byte/word host interface logic and downstream cipher-text consumers, and computes one AES round per clock.

Parameters:
DW, 8, data/key beat width in bits; legal values 8, 16, 32, 64, 128; any other value is an elaboration error.
NBEATS, 128/DW, derived localparam: beats per 128-bit block.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
in_valid  in  1  input beat valid
in_ready  out  1  core accepts input beat
in_data  in  DW  plaintext beat, MSB-first across the block
in_key  in  DW  key beat, MSB-first, same beat alignment as in_data
in_new_key  in  1  sampled on first beat only: 1 = load key from in_key, 0 = reuse stored key
out_valid  out  1  cipher-text beat valid
out_ready  in  1  consumer accepts beat
out_data  out  DW  cipher-text beat, MSB-first
busy  out  1  high in ROUND and OUT states

Behaviour:
- Reset is synchronous and active-high on clk. After reset: state=LOAD, in_ready=1, out_valid=0, out_data=0, busy=0, stored key=0, beat counter=0, round counter=0.
- A handshake occurs when valid and ready are both high at a rising edge. The first beat of a block fills bits [127:128-DW]. Beat k fills bits [127-k*DW -: DW].
- LOAD state:
  - in_ready=1.
  - On the first beat, in_new_key is latched. If it is 1, in_key beats are written into the key register for every beat of the block. If it is 0, in_key is ignored and the stored key is kept.
  - in_new_key on beats 2..NBEATS is ignored.
  - The handshake on beat NBEATS moves to ROUND with rnd=0. in_ready drops in the next cycle.
- ROUND state:
  - in_ready=0. One edge per round.
  - rnd=0: state ^= cipher key; round-key register <= cipher key.
  - rnd=1..9: state <= MixColumns(ShiftRows(SubBytes(state))) ^ next round key, where next round key = expansion(round key, rcon[rnd]); the round-key register takes the new value.
  - rnd=10: same as above but without MixColumns. Then move to OUT.
  - The ROUND state occupies exactly 11 edges. out_valid first rises 11 edges after the last input handshake.
  - The stored cipher key is never overwritten by round keys.
- OUT state:
  - out_valid=1, and out_data = state[127-k*DW -: DW] for beat k.
  - out_data and out_valid stay stable while out_ready=0.
  - The handshake on beat NBEATS returns to LOAD: out_valid=0 and in_ready=1 in the next cycle.
- No input/output overlap: in_ready=0 throughout ROUND and OUT, even if in_valid is high.
- in_valid low mid-block: the core waits indefinitely in LOAD, and the beat counter holds.
- DW=128: one-beat load, one-beat drain; in_new_key applies to that single beat.
- Reset asserted in any state aborts the current block. The stored key is cleared to 0, and all outputs take their reset values on the next edge.
- in_key/in_data values when in_valid=0 are don't-care. out_data is don't-care-free: it holds its last value when out_valid=0.

Decomposition:
- Package aes_pkg holds:
  - the S-box function;
  - xtime and GF(2^8) mul2/mul3 functions;
  - the rcon table (01,02,04,08,10,20,40,80,1b,36, indexed rnd-1);
  - the state enum {LOAD, ROUND, OUT};
  - the AES_BLK=128 constant.
- Sub-module aes_round_comb is purely combinational:
  - inputs: state, round key, rcon, last_round flag;
  - outputs: next state and next round key.
- The top module contains the FSM, the beat and round counters, the key register and the beat mux/demux.

Test Plan:
- DW=8, in_new_key=1, key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> out 69c4e0d86a7b0430d8cdb78070b4c55a over 16 beats; first out_valid 11 edges after beat 16.
- DW=32, key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> out 3925841d02dc09fbdc118597196a0b32 in 4 beats.
- Key reuse, DW=8: block 1 as in the first scenario; block 2 with in_new_key=0, in_key=ff..ff, same pt -> 69c4e0d86a7b0430d8cdb78070b4c55a again.
- Back-pressure, DW=16: random in_valid gaps and out_ready toggling (hold low 5 cycles mid-drain) -> out_data stable while stalled; same result as the FIPS-197 Appendix C.1 vector; in_ready=0 during ROUND/OUT.
- Reset mid-ROUND (rnd=5) then new block with in_new_key=0 -> stored key is 0. Key 00..00, pt 00..00 -> 66e94bd4ef8a2c3b884cfa59ca342b2e.
- DW=128: single-beat load/drain, back-to-back blocks -> in_ready rises on the cycle after the output handshake; throughput is one block per 13 cycles with ready/valid held high.
